// File: rtl/riscv_pkg.sv
// Shared types for the memory-side blocks: arbiter FSM states, requester
// identities and the fetch half-word select helper.
package riscv_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam logic [7:0] FETCH_BYTE_EN = 8'hFF;

  // Fetches are 32-bit; the memory beat is 64-bit and addr[2] picks the half.
  function automatic logic [31:0] fetch_word(input logic [63:0] beat,
                                             input logic        upper);
    return upper ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data access) in front of a single-port
// memory with one outstanding read; data has priority, bounded by a starvation limit.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_req,
  input  logic [63:0]                         i_addr,
  output logic                                i_gnt,
  output logic                                i_rvalid,
  output logic [31:0]                         i_rdata,
  input  logic                                d_req,
  input  logic                                d_wen,
  input  logic [63:0]                         d_addr,
  input  logic [63:0]                         d_wdata,
  input  logic [7:0]                          d_byte_en,
  output logic                                d_gnt,
  output logic                                d_rvalid,
  output logic [63:0]                         d_rdata,
  output logic                                m_req,
  output logic                                m_wen,
  output logic [63:0]                         m_addr,
  output logic [63:0]                         m_wdata,
  output logic [7:0]                          m_byte_en,
  input  logic                                m_ready,
  input  logic                                m_rvalid,
  input  logic [63:0]                         m_rdata,
  output arb_state_t                          dbg_state,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]   dbg_starve_cnt
);

  localparam int             CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  // Handshake: a requester raises *_req with stable payload and holds it until
  // the cycle its *_gnt is high (m_req & m_ready); reads complete later with a
  // one-cycle *_rvalid. Memory accepts with m_ready and answers with m_rvalid.

  arb_state_t    state_q, state_d;
  logic          lock_q, lock_d;
  arb_owner_t    lock_own_q, lock_own_d;
  arb_owner_t    owner_q, owner_d;
  logic          addr2_q, addr2_d;
  logic [CW-1:0] starve_q, starve_d;

  logic       locked_live;
  logic       issue;
  logic       accept;
  logic       is_read;
  logic       rsp;
  arb_owner_t sel;

  // A pending but unaccepted request keeps its owner even if the other side
  // would now win; the lock is only honoured while that owner still requests.
  always_comb begin
    locked_live = lock_q && ((lock_own_q == OWN_I) ? i_req : d_req);
    if (locked_live) begin
      sel = lock_own_q;
    end else if (i_req && (starve_q == LIMIT)) begin
      sel = OWN_I;
    end else if (d_req) begin
      sel = OWN_D;
    end else begin
      sel = OWN_I;
    end
    issue   = !rst && (state_q == IDLE) && (i_req || d_req);
    is_read = (sel == OWN_I) || !d_wen;
  end

  always_comb begin
    m_req     = 1'b0;
    m_wen     = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_byte_en = '0;
    if (issue) begin
      m_req = 1'b1;
      if (sel == OWN_I) begin
        m_addr    = i_addr;
        m_byte_en = FETCH_BYTE_EN;
      end else begin
        m_wen     = d_wen;
        m_addr    = d_addr;
        m_wdata   = d_wdata;
        m_byte_en = d_byte_en;
      end
    end
  end

  always_comb begin
    accept   = m_req && m_ready;
    i_gnt    = accept && (sel == OWN_I);
    d_gnt    = accept && (sel == OWN_D);
    rsp      = !rst && (state_q == RD_WAIT) && m_rvalid;
    i_rvalid = rsp && (owner_q == OWN_I);
    d_rvalid = rsp && (owner_q == OWN_D);
    i_rdata  = i_rvalid ? fetch_word(m_rdata, addr2_q) : '0;
    d_rdata  = d_rvalid ? m_rdata : '0;
  end

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    owner_d    = owner_q;
    addr2_d    = addr2_q;
    starve_d   = starve_q;
    case (state_q)
      IDLE: begin
        lock_d     = m_req && !m_ready;
        lock_own_d = sel;
        if (accept && is_read) begin
          state_d = RD_WAIT;
          owner_d = sel;
          addr2_d = (sel == OWN_I) ? i_addr[2] : d_addr[2];
        end
      end
      RD_WAIT: begin
        if (m_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Fairness counter only tracks data wins while a fetch is actually waiting.
    if (!i_req || i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      lock_own_q <= OWN_I;
      owner_q    <= OWN_I;
      addr2_q    <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      owner_q    <= owner_d;
      addr2_q    <= addr2_d;
      starve_q   <= starve_d;
    end
  end

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_gnt && d_gnt));
      assert (!(i_rvalid && d_rvalid));
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  import riscv_pkg::*;

  localparam int STARVE_LIMIT = 4;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [63:0]   i_addr;
  logic [31:0]   i_rdata;
  logic          d_req, d_wen, d_gnt, d_rvalid;
  logic [63:0]   d_addr, d_wdata, d_rdata;
  logic [7:0]    d_byte_en;
  logic          m_req, m_wen, m_ready, m_rvalid;
  logic [63:0]   m_addr, m_wdata, m_rdata;
  logic [7:0]    m_byte_en;
  arb_state_t    dbg_state;
  logic [CW-1:0] dbg_starve_cnt;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_byte_en(d_byte_en),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_byte_en(m_byte_en),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // exp_q holds outstanding reads as {is_data, addr2}; at most one by protocol.
  logic [1:0] exp_q[$];
  int         lock_who  = 0;   // 0 none, 1 instruction, 2 data
  int         streak    = 0;   // consecutive data wins while a fetch waits
  logic       mdl_i_gnt = 1'b0;
  logic       mdl_d_gnt = 1'b0;
  logic       mdl_rd_acc = 1'b0;

  task automatic model_step();
    int         who;
    logic       acc;
    logic       e_ir, e_dr;
    logic [1:0] ent;
    mdl_i_gnt  = 1'b0;
    mdl_d_gnt  = 1'b0;
    mdl_rd_acc = 1'b0;
    if (rst) begin
      check1("rst_m_req", m_req, 1'b0);
      check64("rst_m_byte_en", 64'(m_byte_en), 64'h0);
      check1("rst_i_gnt", i_gnt, 1'b0);
      check1("rst_d_gnt", d_gnt, 1'b0);
      check1("rst_i_rvalid", i_rvalid, 1'b0);
      check1("rst_d_rvalid", d_rvalid, 1'b0);
      check64("rst_starve", 64'(dbg_starve_cnt), 64'h0);
      exp_q.delete();
      lock_who = 0;
      streak   = 0;
      return;
    end
    check64("starve_cnt", 64'(dbg_starve_cnt), 64'(streak));
    if (exp_q.size() != 0) begin
      check1("wait_m_req", m_req, 1'b0);
      check1("wait_i_gnt", i_gnt, 1'b0);
      check1("wait_d_gnt", d_gnt, 1'b0);
      e_ir = 1'b0;
      e_dr = 1'b0;
      if (m_rvalid) begin
        ent  = exp_q.pop_front();
        e_ir = !ent[1];
        e_dr = ent[1];
        if (e_ir) check64("i_rdata", 64'(i_rdata), ent[0] ? 64'(m_rdata[63:32]) : 64'(m_rdata[31:0]));
        if (e_dr) check64("d_rdata", d_rdata, m_rdata);
      end
      check1("i_rvalid", i_rvalid, e_ir);
      check1("d_rvalid", d_rvalid, e_dr);
      if (!i_req) streak = 0;
    end else begin
      if ((lock_who == 1 && i_req) || (lock_who == 2 && d_req)) who = lock_who;
      else if (i_req && streak >= STARVE_LIMIT)                  who = 1;
      else if (d_req)                                            who = 2;
      else if (i_req)                                            who = 1;
      else                                                       who = 0;
      check1("idle_i_rvalid", i_rvalid, 1'b0);
      check1("idle_d_rvalid", d_rvalid, 1'b0);
      check1("m_req", m_req, who != 0);
      acc = (who != 0) && m_ready;
      check1("i_gnt", i_gnt, acc && who == 1);
      check1("d_gnt", d_gnt, acc && who == 2);
      if (who == 1) begin
        check64("m_addr_i", m_addr, i_addr);
        check1("m_wen_i", m_wen, 1'b0);
        check64("m_byte_en_i", 64'(m_byte_en), 64'hFF);
      end else if (who == 2) begin
        check64("m_addr_d", m_addr, d_addr);
        check1("m_wen_d", m_wen, d_wen);
        check64("m_byte_en_d", 64'(m_byte_en), 64'(d_byte_en));
        if (d_wen) check64("m_wdata_d", m_wdata, d_wdata);
      end
      if (acc && (who == 1 || !d_wen)) begin
        exp_q.push_back({who == 2, (who == 1) ? i_addr[2] : d_addr[2]});
        mdl_rd_acc = 1'b1;
      end
      mdl_i_gnt = acc && who == 1;
      mdl_d_gnt = acc && who == 2;
      lock_who  = (who != 0 && !m_ready) ? who : 0;
      if (!i_req || mdl_i_gnt) streak = 0;
      else if (mdl_d_gnt && streak < STARVE_LIMIT) streak++;
    end
  endtask

  always @(negedge clk) model_step();

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [63:0] data);
    m_rvalid = 1'b1;
    m_rdata  = data;
    tick();
    m_rvalid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int   dgnt_cnt;
  logic seen_ignt;
  logic rsp_busy;
  int   rsp_wait;

  initial begin
    rst = 1'b1; i_req = 1'b1; i_addr = 64'h40;
    d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_byte_en = '0;
    m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
    repeat (2) @(negedge clk);
    check1("reset_m_req", m_req, 1'b0);
    check64("reset_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0; i_req = 1'b0;
    tick();

    // single fetch, upper half, data back two cycles after issue
    i_req = 1'b1; i_addr = 64'h1004;
    @(negedge clk);
    check1("fetch_i_gnt", i_gnt, 1'b1);
    check64("fetch_m_addr", m_addr, 64'h1004);
    tick(); i_req = 1'b0;
    @(negedge clk);
    check1("fetch_no_early_rvalid", i_rvalid, 1'b0);
    tick(); m_rvalid = 1'b1; m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    check1("fetch_i_rvalid", i_rvalid, 1'b1);
    check64("fetch_i_rdata", 64'(i_rdata), 64'hAAAA_BBBB);
    tick(); m_rvalid = 1'b0;
    @(negedge clk);
    check1("fetch_rvalid_1cyc", i_rvalid, 1'b0);
    tick();

    // simultaneous fetch and data read: data first, fetch after d_rvalid
    i_req = 1'b1; i_addr = 64'h3000;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 64'h2000;
    @(negedge clk);
    check1("both_d_first", d_gnt, 1'b1);
    check1("both_i_held", i_gnt, 1'b0);
    tick(); d_req = 1'b0;
    @(negedge clk);
    check1("both_i_wait", i_gnt, 1'b0);
    tick(); m_rvalid = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    check1("both_d_rvalid", d_rvalid, 1'b1);
    check64("both_d_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
    check1("both_i_not_same", i_gnt, 1'b0);
    tick(); m_rvalid = 1'b0;
    @(negedge clk);
    check1("both_i_after", i_gnt, 1'b1);
    check64("both_i_addr", m_addr, 64'h3000);
    tick(); i_req = 1'b0;
    drain(64'h0);

    // starvation bound with back-to-back data writes
    i_req = 1'b1; i_addr = 64'h4000;
    d_req = 1'b1; d_wen = 1'b1; d_addr = 64'h9000; d_wdata = 64'h55; d_byte_en = 8'hFF;
    dgnt_cnt = 0; seen_ignt = 1'b0;
    for (int c = 0; c < 20 && !seen_ignt; c++) begin
      @(negedge clk);
      if (d_gnt) dgnt_cnt++;
      if (i_gnt) seen_ignt = 1'b1;
      else tick();
    end
    check1("starve_i_gnt_seen", seen_ignt, 1'b1);
    check64("starve_d_gnt_count", 64'(dgnt_cnt), 64'd4);
    tick(); i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check64("starve_cleared", 64'(dbg_starve_cnt), 64'd0);
    tick();
    drain(64'h0);

    // stalled fetch keeps ownership while a data request appears
    i_req = 1'b1; i_addr = 64'h5008; m_ready = 1'b0;
    @(negedge clk);
    check64("lock_addr_0", m_addr, 64'h5008);
    tick(); d_req = 1'b1; d_wen = 1'b0; d_addr = 64'h6000;
    @(negedge clk);
    check64("lock_addr_1", m_addr, 64'h5008);
    check1("lock_no_d_gnt", d_gnt, 1'b0);
    tick();
    @(negedge clk);
    check64("lock_addr_2", m_addr, 64'h5008);
    tick(); m_ready = 1'b1;
    @(negedge clk);
    check1("lock_i_gnt", i_gnt, 1'b1);
    check1("lock_d_gnt_off", d_gnt, 1'b0);
    tick(); i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hFEED_FACE_1357_2468;
    @(negedge clk);
    check64("lock_i_rdata_lo", 64'(i_rdata), 64'h1357_2468);
    tick(); m_rvalid = 1'b0;
    @(negedge clk);
    check1("lock_d_next", d_gnt, 1'b1);
    tick(); d_req = 1'b0;
    drain(64'h0);

    // reset while a read is outstanding, then a late response
    i_req = 1'b1; i_addr = 64'h7000;
    @(negedge clk);
    check1("rstwait_i_gnt", i_gnt, 1'b1);
    tick(); i_req = 1'b0;
    check64("rstwait_in_rd", 64'(dbg_state), 64'(RD_WAIT));
    rst = 1'b1;
    @(negedge clk);
    check64("rstwait_state", 64'(dbg_state), 64'(IDLE));
    tick(); rst = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    check1("late_no_i_rvalid", i_rvalid, 1'b0);
    check1("late_no_d_rvalid", d_rvalid, 1'b0);
    check64("late_state", 64'(dbg_state), 64'(IDLE));
    tick(); m_rvalid = 1'b0;

    // partial data write
    d_req = 1'b1; d_wen = 1'b1; d_addr = 64'h8000;
    d_wdata = 64'h1122_3344_5566_7788; d_byte_en = 8'h0F;
    @(negedge clk);
    check1("wr_m_wen", m_wen, 1'b1);
    check64("wr_m_byte_en", 64'(m_byte_en), 64'h0F);
    check64("wr_m_wdata", m_wdata, 64'h1122_3344_5566_7788);
    check1("wr_d_gnt", d_gnt, 1'b1);
    tick(); d_req = 1'b0; m_rvalid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check1("wr_no_d_rvalid", d_rvalid, 1'b0);
      tick();
    end
    m_rvalid = 1'b0;
    tick();

    // randomized traffic; requesters hold until granted, memory answers reads
    // after 1-4 cycles and occasionally raises a stray m_rvalid while idle
    rsp_busy = 1'b0; rsp_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      if (i_req && mdl_i_gnt) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req  = 1'b1;
        i_addr = {$urandom, $urandom};
      end
      if (d_req && mdl_d_gnt) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req     = 1'b1;
        d_wen     = 1'($urandom_range(0, 1));
        d_addr    = {$urandom, $urandom};
        d_wdata   = {$urandom, $urandom};
        d_byte_en = 8'($urandom_range(0, 255));
      end
      m_ready = ($urandom_range(0, 3) != 0);
      if (mdl_rd_acc) begin
        rsp_busy = 1'b1;
        rsp_wait = $urandom_range(0, 3);
      end
      m_rdata = {$urandom, $urandom};
      if (rsp_busy && rsp_wait == 0) begin
        m_rvalid = 1'b1;
        rsp_busy = 1'b0;
      end else begin
        if (rsp_busy) rsp_wait--;
        m_rvalid = !rsp_busy && ($urandom_range(0, 7) == 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the number of consecutive data grants allowed while an instruction request waits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_req, input, 1 bit: instruction fetch request.
REQ-005 The block SHALL have port i_addr, input, 64 bits: fetch byte address.
REQ-006 The block SHALL have port i_gnt, output, 1 bit: fetch accepted by memory this cycle.
REQ-007 The block SHALL have ports i_rvalid (output, 1 bit) and i_rdata (output, 32 bits): fetch data return.
REQ-008 The block SHALL have ports d_req (input, 1), d_wen (input, 1), d_addr (input, 64), d_wdata (input, 64) and d_byte_en (input, 8): the data access request.
REQ-009 The block SHALL have ports d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, 64): data accept and read return.
REQ-010 The block SHALL have ports m_req (output, 1), m_wen (output, 1), m_addr (output, 64), m_wdata (output, 64) and m_byte_en (output, 8): the shared single-port memory request.
REQ-011 The block SHALL have ports m_ready (input, 1), m_rvalid (input, 1) and m_rdata (input, 64): memory accept and read return.

Function
REQ-012 The FSM SHALL have two states: IDLE (no read outstanding) and RD_WAIT (one read outstanding); at most one transaction is outstanding at any time.
REQ-013 In IDLE with any request pending, the block SHALL drive m_req=1 and route the selected requester's address, write data, byte enables and wen to the m_* outputs combinationally; fetches SHALL drive m_wen=0 and m_byte_en=8'hFF.
REQ-014 Selection SHALL give data priority unless the starvation counter equals STARVE_LIMIT and i_req=1, in which case the instruction requester SHALL win.
REQ-015 Once m_req is asserted for an owner and m_ready=0, the selection SHALL be locked (registered) until acceptance; a higher-priority request arriving meanwhile SHALL NOT switch the owner.
REQ-016 On acceptance (m_req & m_ready), the block SHALL pulse the owner's gnt in the same cycle; a read SHALL move to RD_WAIT with the owner and addr[2] registered; a write SHALL remain in IDLE with no rvalid.
REQ-017 In RD_WAIT, the block SHALL hold m_req=0; on m_rvalid it SHALL pulse the owner's rvalid for exactly 1 cycle and return to IDLE, so the next request issues no earlier than the following cycle.
REQ-018 i_rdata SHALL be m_rdata[63:32] when the registered addr[2]=1, else m_rdata[31:0]; d_rdata SHALL be m_rdata unmodified.
REQ-019 The starvation counter SHALL increment, saturating at STARVE_LIMIT, on each data grant while i_req=1, and SHALL clear on an instruction grant or whenever i_req=0.
REQ-020 An m_rvalid received in IDLE SHALL be ignored and no rvalid SHALL be produced.
REQ-021 The block SHALL NOT assert i_gnt and d_gnt in the same cycle, and SHALL NOT assert i_rvalid and d_rvalid in the same cycle.

Reset
REQ-022 While rst=1, the block SHALL hold the FSM in IDLE, the lock, owner and addr[2] registers clear, the starvation counter at 0, and all outputs at 0 (m_byte_en=0, all gnt/rvalid=0).
REQ-023 A reset during RD_WAIT SHALL drop the outstanding read; a late m_rvalid after reset release SHALL be ignored per REQ-020.

Structure
REQ-024 The arb_state_t enum (IDLE, RD_WAIT) and the arb_owner_t enum (OWN_I, OWN_D) SHALL live in riscv_pkg.
REQ-025 The block SHALL be a single module with no sub-modules; the starvation counter SHALL be $clog2(STARVE_LIMIT+1) bits wide.

Verification
REQ-026 The bench SHALL drive i_req only, with i_addr=0x1004 and m_rdata=0xAAAA_BBBB_CCCC_DDDD returned 2 cycles later, and SHALL check i_gnt=1 on the issue cycle and i_rvalid=1 for 1 cycle with i_rdata=0xAAAA_BBBB.
REQ-027 The bench SHALL drive i_req and d_req (read) together in the same cycle, and SHALL check that d_gnt is first, i_gnt follows only after d_rvalid, and the fetch issues on the cycle after d_rvalid.
REQ-028 The bench SHALL drive d_req (write) continuously with i_req=1 and m_ready=1, at STARVE_LIMIT=4, and SHALL check that exactly 4 d_gnt pulses occur, then i_gnt, then the counter is 0.
REQ-029 The bench SHALL hold m_ready=0 for 3 cycles during an instruction request, raise d_req in cycle 2, and SHALL check that m_addr stays at i_addr and i_gnt occurs when m_ready rises.
REQ-030 The bench SHALL assert rst in RD_WAIT, then drive m_rvalid=1 after release, and SHALL check that no i_rvalid/d_rvalid occurs and the FSM is in IDLE.
REQ-031 The bench SHALL drive a data write with d_byte_en=0x0F and d_wdata=0x1122_3344_5566_7788, and SHALL check that m_wen=1, m_byte_en=0x0F, m_wdata matches, d_gnt=1 and d_rvalid never asserts.
